// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer encodings and arbiter state type
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Undefined-length INCR is treated like SINGLE: it can be cut at any beat.
    function automatic logic [4:0] burst_len(hburst_e burst);
        case (burst)
            WRAP4, INCR4:   burst_len = 5'd4;
            WRAP8, INCR8:   burst_len = 5'd8;
            WRAP16, INCR16: burst_len = 5'd16;
            default:        burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// rtl/ahb_rr_pick.sv - combinational round-robin winner select, one-hot result
module ahb_rr_pick #(
    parameter int NUM_MST     = 3,
    parameter int MST_W       = $clog2(NUM_MST),
    parameter int DEFAULT_MST = 0
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [MST_W-1:0]   last,
    output logic [NUM_MST-1:0] grant
);

    logic             found;
    logic [MST_W-1:0] idx;

    // Search starts one past the last owner and wraps back to it last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            idx = MST_W'((int'(last) + i) % NUM_MST);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!found) begin
            grant[DEFAULT_MST] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// rtl/ahb_lite_arbiter.sv - round-robin AHB-Lite arbiter with burst and lock protection
module ahb_lite_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MST     = 3,
    parameter int MST_W       = $clog2(NUM_MST),
    parameter int DEFAULT_MST = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [MST_W-1:0]   HMASTER,
    output logic [MST_W-1:0]   HMASTER_D,
    output logic               HMASTLOCK
);

    localparam logic [NUM_MST-1:0] DEFAULT_GRANT = NUM_MST'(1) << DEFAULT_MST;
    localparam logic [MST_W-1:0]   DEFAULT_IDX   = MST_W'(DEFAULT_MST);

    arb_state_e         state_q, state_next;
    logic [4:0]         beats_q, beats_next;
    logic [NUM_MST-1:0] grant_q, grant_pick;
    logic [MST_W-1:0]   master_q, master_d_q, grant_idx;
    logic               mastlock_q;
    logic               lock_req;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_q[i]) begin
                grant_idx = MST_W'(i);
            end
        end
    end

    // Rotation is relative to the granted master so back-to-back singles
    // move the grant on every edge rather than every other edge.
    ahb_rr_pick #(
        .NUM_MST     (NUM_MST),
        .MST_W       (MST_W),
        .DEFAULT_MST (DEFAULT_MST)
    ) u_rr_pick (
        .req   (HBUSREQ),
        .last  (grant_idx),
        .grant (grant_pick)
    );

    always_comb begin
        beats_next = beats_q;
        case (htrans_e'(HTRANS))
            NONSEQ:  beats_next = burst_len(hburst_e'(HBURST)) - 5'd1;
            SEQ:     beats_next = (beats_q != 5'd0) ? beats_q - 5'd1 : 5'd0;
            IDLE:    beats_next = 5'd0;
            default: beats_next = beats_q;
        endcase
    end

    assign lock_req = HLOCK[master_q];

    // Releasing the grant at one beat left lets the next owner's NONSEQ
    // follow the final beat with no dead cycle.
    always_comb begin
        state_next = state_q;
        if (lock_req) begin
            state_next = LOCKED;
        end else begin
            case (state_q)
                ARB:     state_next = (beats_next > 5'd1) ? BURST : ARB;
                BURST:   state_next = (beats_next > 5'd1) ? BURST : ARB;
                LOCKED:  state_next = (beats_next > 5'd1) ? LOCKED : ARB;
                default: state_next = ARB;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ARB;
        end else if (HREADY) begin
            state_q <= state_next;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beats_q    <= 5'd0;
            grant_q    <= DEFAULT_GRANT;
            master_q   <= DEFAULT_IDX;
            master_d_q <= DEFAULT_IDX;
            mastlock_q <= 1'b0;
        end else if (HREADY) begin
            beats_q    <= beats_next;
            if (state_next == ARB) begin
                grant_q <= grant_pick;
            end
            master_q   <= grant_idx;
            master_d_q <= master_q;
            mastlock_q <= HLOCK[grant_idx];
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTER_D = master_d_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb/tb_ahb_lite_arbiter.sv - directed self-checking bench for ahb_lite_arbiter
module tb_ahb_lite_arbiter;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NS     = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_INCR16 = 3'd7;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    ahb_lite_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] g, input logic [1:0] m, input logic [1:0] md);
        check({tag, ".grant"}, 8'(HGRANT), 8'(g));
        check({tag, ".master"}, 8'(HMASTER), 8'(m));
        check({tag, ".master_d"}, 8'(HMASTER_D), 8'(md));
    endtask

    task automatic step(input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        HTRANS = tr;
        HBURST = bu;
        HREADY = rdy;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = 3'b000;
        HLOCK   = 3'b000;
        HTRANS  = T_IDLE;
        HBURST  = B_SINGLE;
        HREADY  = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset", 3'b001, 2'd0, 2'd0);
        check("reset.lock", 8'(HMASTLOCK), 8'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(T_IDLE, B_SINGLE, 1'b1);
            chk("idle", 3'b001, 2'd0, 2'd0);
        end

        // Back-to-back singles from all three masters
        HBUSREQ = 3'b111;
        step(T_NS, B_SINGLE, 1'b1); chk("rot1", 3'b010, 2'd0, 2'd0);
        step(T_NS, B_SINGLE, 1'b1); chk("rot2", 3'b100, 2'd1, 2'd0);
        step(T_NS, B_SINGLE, 1'b1); chk("rot3", 3'b001, 2'd2, 2'd1);
        step(T_NS, B_SINGLE, 1'b1); chk("rot4", 3'b010, 2'd0, 2'd2);

        // INCR8 by master 1 with master 2 waiting
        HBUSREQ = 3'b010;
        step(T_IDLE, B_SINGLE, 1'b1); chk("i8.own", 3'b010, 2'd1, 2'd0);
        HBUSREQ = 3'b110;
        step(T_NS, B_INCR8, 1'b1); chk("i8.ns", 3'b010, 2'd1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            step(T_SEQ, B_INCR8, 1'b1); chk("i8.hold", 3'b010, 2'd1, 2'd1);
        end
        step(T_SEQ, B_INCR8, 1'b1); chk("i8.b7", 3'b100, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("i8.b8", 3'b010, 2'd2, 2'd1);

        // Same burst with a three-cycle stall on beat 4
        HBUSREQ = 3'b010;
        step(T_IDLE, B_SINGLE, 1'b1); chk("st.own", 3'b010, 2'd1, 2'd2);
        HBUSREQ = 3'b110;
        step(T_NS, B_INCR8, 1'b1); chk("st.ns", 3'b010, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b2", 3'b010, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b3", 3'b010, 2'd1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            step(T_SEQ, B_INCR8, 1'b0); chk("st.wait", 3'b010, 2'd1, 2'd1);
        end
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b4", 3'b010, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b5", 3'b010, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b6", 3'b010, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b7", 3'b100, 2'd1, 2'd1);
        step(T_SEQ, B_INCR8, 1'b1); chk("st.b8", 3'b010, 2'd2, 2'd1);

        // Master 0 locked across two INCR4 bursts
        HBUSREQ = 3'b001;
        step(T_IDLE, B_SINGLE, 1'b1); chk("lk.pre1", 3'b001, 2'd1, 2'd2);
        step(T_IDLE, B_SINGLE, 1'b1); chk("lk.pre2", 3'b001, 2'd0, 2'd1);
        HBUSREQ = 3'b110;
        HLOCK   = 3'b001;
        step(T_NS, B_INCR4, 1'b1);
        check("lk.ns.grant", 8'(HGRANT), 8'(3'b001));
        check("lk.ns.lock", 8'(HMASTLOCK), 8'd1);
        for (int i = 0; i < 3; i++) begin
            step(T_SEQ, B_INCR4, 1'b1);
            check("lk.a.grant", 8'(HGRANT), 8'(3'b001));
            check("lk.a.lock", 8'(HMASTLOCK), 8'd1);
        end
        step(T_NS, B_INCR4, 1'b1);
        check("lk.b.grant", 8'(HGRANT), 8'(3'b001));
        for (int i = 0; i < 2; i++) begin
            step(T_SEQ, B_INCR4, 1'b1);
            check("lk.b.grant", 8'(HGRANT), 8'(3'b001));
            check("lk.b.lock", 8'(HMASTLOCK), 8'd1);
        end
        HLOCK = 3'b000;
        step(T_SEQ, B_INCR4, 1'b1);
        chk("lk.rel", 3'b010, 2'd0, 2'd0);
        check("lk.rel.lock", 8'(HMASTLOCK), 8'd0);
        step(T_IDLE, B_SINGLE, 1'b1); chk("lk.next", 3'b100, 2'd1, 2'd0);

        // Asynchronous reset in the middle of an INCR16 by master 2
        HBUSREQ = 3'b100;
        step(T_IDLE, B_SINGLE, 1'b1); chk("rs.own", 3'b100, 2'd2, 2'd1);
        step(T_NS, B_INCR16, 1'b1); chk("rs.ns", 3'b100, 2'd2, 2'd2);
        HBUSREQ = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step(T_SEQ, B_INCR16, 1'b1); chk("rs.hold", 3'b100, 2'd2, 2'd2);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rs.async", 3'b001, 2'd0, 2'd0);
        check("rs.async.lock", 8'(HMASTLOCK), 8'd0);
        @(posedge HCLK);
        #1;
        chk("rs.low", 3'b001, 2'd0, 2'd0);
        HRESETn = 1'b1;
        HBUSREQ = 3'b010;
        step(T_SEQ, B_INCR16, 1'b1); chk("rs.arb1", 3'b010, 2'd0, 2'd0);
        step(T_SEQ, B_INCR16, 1'b1); chk("rs.arb2", 3'b010, 2'd1, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
